// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: issue opcodes and FSM states.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } mdu_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
// Purely combinational; no backpressure (the caller sequences one step per cycle).
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dsor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic           fits;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, dsor_i});

    // The partial remainder stays below the divisor, so the kept value always fits in WIDTH bits.
    assign rem_o = fits ? WIDTH'(shifted - {1'b0, dsor_i}) : shifted[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], fits};

endmodule

// File: rtl/hilo_mdu.sv
// EX-stage multiply/divide unit with architectural HI/LO; multiply lands MUL_LAT edges after issue,
// divide WIDTH+1 edges after issue. start is ignored while busy (no queueing); flush cancels in flight.
module hilo_mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    input  logic             rhl_sel,
    output logic             busy,
    output logic [WIDTH-1:0] rhl_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 16);

    mdu_state_e          state_q;
    logic [CW-1:0]       cnt_q;
    logic [WIDTH-1:0]    hi_q, lo_q;
    logic [2*WIDTH-1:0]  acc_q;
    logic [WIDTH-1:0]    dsor_q;
    logic                negq_q, negr_q;
    logic                busy_q;

    logic                mul_sgn, div_sgn;
    logic [2*WIDTH-1:0]  mul_a, mul_b, product_d;
    logic [WIDTH-1:0]    abs_rs_d, abs_rt_d;
    logic [WIDTH-1:0]    rem_d, quo_d;
    logic [WIDTH-1:0]    quo_fix_d, rem_fix_d;

    assign mul_sgn   = (op == MDU_MULT);
    assign div_sgn   = (op == MDU_DIV);

    // Low 2W bits of the sign-extended product equal the exact signed product.
    assign mul_a     = {{WIDTH{mul_sgn & rs_data[WIDTH-1]}}, rs_data};
    assign mul_b     = {{WIDTH{mul_sgn & rt_data[WIDTH-1]}}, rt_data};
    assign product_d = mul_a * mul_b;

    assign abs_rs_d  = (div_sgn && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    assign abs_rt_d  = (div_sgn && rt_data[WIDTH-1]) ? -rt_data : rt_data;

    // During a divide acc_q holds {partial remainder, dividend/quotient shift register}.
    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i  (acc_q[2*WIDTH-1:WIDTH]),
        .quo_i  (acc_q[WIDTH-1:0]),
        .dsor_i (dsor_q),
        .rem_o  (rem_d),
        .quo_o  (quo_d)
    );

    assign quo_fix_d = negq_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
    assign rem_fix_d = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
            dsor_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            MDU_MULT, MDU_MULTU: begin
                                acc_q   <= product_d;
                                cnt_q   <= CW'(MUL_LAT - 1);
                                state_q <= ST_MUL;
                                busy_q  <= 1'b1;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                acc_q   <= {{WIDTH{1'b0}}, abs_rs_d};
                                dsor_q  <= abs_rt_d;
                                negq_q  <= div_sgn & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                                negr_q  <= div_sgn & rs_data[WIDTH-1];
                                cnt_q   <= CW'(WIDTH - 1);
                                state_q <= ST_DIV;
                                busy_q  <= 1'b1;
                            end
                            MDU_MTHI: hi_q <= rs_data;
                            MDU_MTLO: lo_q <= rs_data;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == '0) begin
                        hi_q    <= acc_q[2*WIDTH-1:WIDTH];
                        lo_q    <= acc_q[WIDTH-1:0];
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ST_DIV: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= {rem_d, quo_d};
                        if (cnt_q == '0) begin
                            state_q <= ST_FIX;
                        end else begin
                            cnt_q <= cnt_q - CW'(1);
                        end
                    end
                end
                ST_FIX: begin
                    if (!flush) begin
                        lo_q <= quo_fix_d;
                        hi_q <= rem_fix_d;
                    end
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign rhl_out = rhl_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_mdu.sv
// Randomized + directed bench for hilo_mdu against a transaction-level HI/LO model.
module tb_hilo_mdu;

    localparam int W  = 32;
    localparam int ML = 2;
    localparam int DL = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic         rhl_sel = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] rs_data = '0;
    logic [W-1:0] rt_data = '0;
    logic         busy;
    logic [W-1:0] rhl_out, hi, lo;

    int vectors = 0;
    int errors  = 0;

    // Model: one pending result plus the number of edges until it lands.
    bit           pend = 1'b0;
    int           left = 0;
    logic [W-1:0] res_hi = '0, res_lo = '0;
    logic [W-1:0] hi_m = '0, lo_m = '0;

    hilo_mdu #(.WIDTH(W), .MUL_LAT(ML)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .flush   (flush),
        .rhl_sel (rhl_sel),
        .busy    (busy),
        .rhl_out (rhl_out),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic calc(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb;
        logic [63:0]  p;
        logic [W-1:0] ua, ub, q, r;
        bit           sg;
        if (o <= 3'd1) begin
            if (o == 3'd0) begin
                sa = $signed(a);
                sb = $signed(b);
                p  = sa * sb;
            end else begin
                p = {32'b0, a} * {32'b0, b};
            end
            res_hi = p[63:32];
            res_lo = p[31:0];
        end else begin
            sg = (o == 3'd2);
            ua = (sg && a[W-1]) ? -a : a;
            ub = (sg && b[W-1]) ? -b : b;
            if (ub == 0) begin
                q = '1;
                r = ua;
            end else begin
                q = ua / ub;
                r = ua % ub;
            end
            if (sg && (a[W-1] ^ b[W-1])) q = -q;
            if (sg && a[W-1]) r = -r;
            res_lo = q;
            res_hi = r;
        end
    endtask

    task automatic model_reset;
        pend = 1'b0;
        left = 0;
        hi_m = '0;
        lo_m = '0;
    endtask

    task automatic model_step;
        if (!rst) begin
            model_reset();
        end else if (pend) begin
            if (flush) begin
                pend = 1'b0;
            end else begin
                left--;
                if (left == 0) begin
                    hi_m = res_hi;
                    lo_m = res_lo;
                    pend = 1'b0;
                end
            end
        end else if (start && !flush) begin
            if (op <= 3'd3) begin
                calc(op, rs_data, rt_data);
                pend = 1'b1;
                left = (op <= 3'd1) ? ML : DL;
            end else if (op == 3'd4) begin
                hi_m = rs_data;
            end else if (op == 3'd5) begin
                lo_m = rs_data;
            end
        end
    endtask

    task automatic compare;
        chk("busy", {31'b0, busy}, {31'b0, pend});
        chk("hi", hi, hi_m);
        chk("lo", lo, lo_m);
        chk("rhl_out", rhl_out, rhl_sel ? hi_m : lo_m);
    endtask

    task automatic tick;
        @(posedge clk);
        model_step();
        #3;
        compare();
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start   = 1'b1;
        op      = o;
        rs_data = a;
        rt_data = b;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        if (busy) chk({name, " timeout"}, {31'b0, busy}, '0);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) tick();
        chk("reset hi", hi, '0);
        chk("reset lo", lo, '0);
        chk("reset busy", {31'b0, busy}, '0);
        rst = 1'b1;
        tick();

        issue(3'd0, 32'hFFFF_FFFD, 32'd5);
        wait_idle("mult", n);
        chk("mult busy cycles", n, 2);
        chk("mult hi", hi, 32'hFFFF_FFFF);
        chk("mult lo", lo, 32'hFFFF_FFF1);

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_idle("multu", n);
        chk("multu hi", hi, 32'hFFFF_FFFE);
        chk("multu lo", lo, 32'h0000_0001);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div", n);
        chk("div busy cycles", n, 33);
        chk("div lo", lo, 32'hFFFF_FFFD);
        chk("div hi", hi, 32'hFFFF_FFFF);

        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("div ovf", n);
        chk("div ovf lo", lo, 32'h8000_0000);
        chk("div ovf hi", hi, 32'h0);

        issue(3'd3, 32'h1234, 32'h0);
        wait_idle("divu zero", n);
        chk("divu zero cycles", n, 33);
        chk("divu zero lo", lo, 32'hFFFF_FFFF);
        chk("divu zero hi", hi, 32'h1234);

        issue(3'd5, 32'hAA, 32'h0);
        chk("mtlo lo", lo, 32'hAA);
        chk("mtlo busy", {31'b0, busy}, '0);

        issue(3'd3, 32'h99, 32'd3);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush busy", {31'b0, busy}, '0);
        chk("flush hi", hi, 32'h1234);
        chk("flush lo", lo, 32'hAA);

        flush = 1'b1;
        issue(3'd4, 32'h77, 32'h0);
        flush = 1'b0;
        chk("start+flush hi", hi, 32'h1234);
        chk("start+flush busy", {31'b0, busy}, '0);

        issue(3'd0, 32'd3, 32'd4);
        start   = 1'b1;
        op      = 3'd4;
        rs_data = 32'h55;
        repeat (2) tick();
        start = 1'b0;
        wait_idle("mult+mthi", n);
        chk("mthi while busy hi", hi, 32'h0);
        chk("mthi while busy lo", lo, 32'd12);

        issue(3'd2, 32'd1000, 32'd7);
        repeat (5) tick();
        rst = 1'b0;
        #1;
        model_reset();
        compare();
        chk("midop reset hi", hi, '0);
        chk("midop reset lo", lo, '0);
        chk("midop reset busy", {31'b0, busy}, '0);
        tick();
        rst = 1'b1;
        tick();

        rhl_sel = 1'b1;
        issue(3'd4, 32'hCAFE_0001, 32'h0);
        chk("rhl_out hi sel", rhl_out, 32'hCAFE_0001);

        for (int i = 0; i < 2500; i++) begin
            start   = ($urandom_range(0, 2) != 0);
            op      = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0: rs_data = 32'h8000_0000;
                1: rs_data = 32'hFFFF_FFFF;
                2: rs_data = 32'($urandom_range(0, 50));
                default: rs_data = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rt_data = 32'h0;
                1: rt_data = 32'hFFFF_FFFF;
                2: rt_data = 32'($urandom_range(1, 9));
                default: rt_data = $urandom;
            endcase
            flush   = ($urandom_range(0, 24) == 0);
            rhl_sel = 1'($urandom_range(0, 1));
            tick();
        end
        start = 1'b0;
        flush = 1'b0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
